pipeline_stall_sequencer: RTL and testbench

- Consumes the data-hazard flag from the decode-stage hazard/bypass controller, plus branch-mispredict and memory-busy status.
- Sequences per-stage stall, bubble and flush controls for the fetch/decode/execute/memoryAccess pipeline registers.
- Owns the multi-cycle cases: memory wait, post-redirect flush window and hazard-stall watchdog.
- Sits directly downstream of the hazard controller; drives the pipeline-register enables.

---
 rtl/pipeline_stall_sequencer.sv | 130 +++++++++++++
 tb/tb_pipeline_stall_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_sequencer.sv
// rtl/pipeline_stall_sequencer.sv - pipeline stall/bubble/flush sequencer; optional perf counters under PIPE_STALL_PERF_EN
module pipeline_stall_sequencer #(
    parameter int unsigned FLUSH_CYCLES     = 2,
    parameter int unsigned MAX_HAZARD_STALL = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        isDataHazard,
    input  logic        branchMispredict,
    input  logic        memBusy,
    output logic        fetchStall,
    output logic        decodeStall,
    output logic        executeBubble,
    output logic        executeStall,
    output logic        memStall,
    output logic        decodeFlush,
    output logic        executeFlush,
    output logic        hazardTimeout,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;

    logic [1:0] r_state;
    logic [3:0] r_flush_cnt;
    logic [7:0] r_hz_run;
    logic       r_timeout;

    logic [1:0] w_state_next;
    logic [3:0] w_flush_next;
    logic [7:0] w_hz_next;

    always_comb begin
        fetchStall    = 1'b0;
        decodeStall   = 1'b0;
        executeBubble = 1'b0;
        executeStall  = 1'b0;
        memStall      = 1'b0;
        decodeFlush   = 1'b0;
        executeFlush  = 1'b0;
        w_state_next  = r_state;
        w_flush_next  = r_flush_cnt;
        w_hz_next     = r_hz_run;
        if (rst) begin
            decodeFlush  = 1'b1;
            executeFlush = 1'b1;
        end else if (memBusy) begin
            // A memory wait inside the flush window freezes it rather than ending it
            fetchStall   = 1'b1;
            decodeStall  = 1'b1;
            executeStall = 1'b1;
            memStall     = 1'b1;
            decodeFlush  = (r_state == S_FLUSH);
            w_state_next = (r_state == S_FLUSH) ? S_FLUSH : S_MEM_WAIT;
        end else if (branchMispredict) begin
            decodeFlush  = 1'b1;
            executeFlush = 1'b1;
            w_flush_next = 4'(FLUSH_CYCLES - 1);
            w_state_next = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
            w_hz_next    = 8'd0;
        end else if (r_state == S_FLUSH) begin
            decodeFlush  = 1'b1;
            w_flush_next = r_flush_cnt - 4'd1;
            w_hz_next    = 8'd0;
            if (r_flush_cnt <= 4'd1) begin
                w_state_next = S_RUN;
            end
        end else if (isDataHazard) begin
            fetchStall    = 1'b1;
            decodeStall   = 1'b1;
            executeBubble = 1'b1;
            w_state_next  = S_RUN;
            w_hz_next     = (r_hz_run == 8'hFF) ? r_hz_run : r_hz_run + 8'd1;
        end else begin
            w_state_next = S_RUN;
            w_hz_next    = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 4'd0;
            r_hz_run    <= 8'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_next;
            r_hz_run    <= w_hz_next;
            // Flag appears the cycle after the run length hits the limit
            if (w_hz_next == 8'(MAX_HAZARD_STALL)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign hazardTimeout = r_timeout;

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;
    logic        w_bm_accept;

    assign w_bm_accept = !rst && !memBusy && branchMispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (fetchStall) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_bm_accept) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stallCount = r_stall_count;
    assign flushCount = r_flush_count;
`else
    assign stallCount = 32'd0;
    assign flushCount = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// tb/tb_pipeline_stall_sequencer.sv - directed plus randomized checks against a behavioural model
module tb_pipeline_stall_sequencer;

    localparam int FC  = 3;
    localparam int MAX = 8;

    logic        clk = 1'b0;
    logic        rst, isDataHazard, branchMispredict, memBusy;
    logic        fetchStall, decodeStall, executeBubble, executeStall, memStall;
    logic        decodeFlush, executeFlush, hazardTimeout;
    logic [31:0] stallCount, flushCount;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: remaining flush cycles after the current one, hazard run length, sticky flag, counts
    int          m_flush_left = 0;
    int          m_run        = 0;
    bit          m_to         = 1'b0;
    bit [31:0]   m_stalls     = 0;
    bit [31:0]   m_flushes    = 0;
    int          seen_dflush  = 0;

    pipeline_stall_sequencer #(.FLUSH_CYCLES(FC), .MAX_HAZARD_STALL(MAX)) dut (
        .clk(clk), .rst(rst), .isDataHazard(isDataHazard),
        .branchMispredict(branchMispredict), .memBusy(memBusy),
        .fetchStall(fetchStall), .decodeStall(decodeStall), .executeBubble(executeBubble),
        .executeStall(executeStall), .memStall(memStall), .decodeFlush(decodeFlush),
        .executeFlush(executeFlush), .hazardTimeout(hazardTimeout),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic b, input logic m);
        bit [6:0] e;  // {fs, ds, eb, es, ms, df, ef}
        rst = r; isDataHazard = h; branchMispredict = b; memBusy = m;
        @(negedge clk);
        e = '0;
        if (r) begin
            e = 7'b0000011;
        end else if (m) begin
            e = {5'b11011, (m_flush_left > 0), 1'b0};
            m_stalls++;
        end else if (b) begin
            e = 7'b0000011;
            m_flush_left = FC - 1;
            m_run = 0;
            m_flushes++;
        end else if (m_flush_left > 0) begin
            e = 7'b0000010;
            m_flush_left--;
            m_run = 0;
        end else if (h) begin
            e = 7'b1110000;
            m_run = (m_run < 255) ? m_run + 1 : 255;
            m_stalls++;
        end else begin
            m_run = 0;
        end
        chk("fetchStall",    32'(fetchStall),    32'(e[6]));
        chk("decodeStall",   32'(decodeStall),   32'(e[5]));
        chk("executeBubble", 32'(executeBubble), 32'(e[4]));
        chk("executeStall",  32'(executeStall),  32'(e[3]));
        chk("memStall",      32'(memStall),      32'(e[2]));
        chk("decodeFlush",   32'(decodeFlush),   32'(e[1]));
        chk("executeFlush",  32'(executeFlush),  32'(e[0]));
        chk("hazardTimeout", 32'(hazardTimeout), 32'(m_to));
`ifdef PIPE_STALL_PERF_EN
        chk("stallCount", stallCount, m_stalls);
        chk("flushCount", flushCount, m_flushes);
`else
        chk("stallCount", stallCount, 32'd0);
        chk("flushCount", flushCount, 32'd0);
`endif
        if (decodeFlush) seen_dflush++;
        if (r) begin
            m_flush_left = 0; m_run = 0; m_to = 1'b0; m_stalls = 0; m_flushes = 0;
        end else if (m_run >= MAX) begin
            m_to = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; isDataHazard = 1'b0; branchMispredict = 1'b0; memBusy = 1'b0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        step(0, 0, 0, 0);
        chk("reset_timeout", 32'(hazardTimeout), 32'd0);

        // single hazard cycle then idle
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // memory wait with mispredict and hazard pending, then the redirect
        step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        seen_dflush = 0;
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("redirect_after_wait_flush_len", 32'(seen_dflush), 32'(FC));

        // mispredict pulse, hazard during the flush window gives no stall
        seen_dflush = 0;
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("flush_window_len", 32'(seen_dflush), 32'(FC));

        // memory wait in second flush cycle stretches the window
        seen_dflush = 0;
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("stretched_flush_len", 32'(seen_dflush), 32'(FC + 2));

        // watchdog
        for (int i = 0; i < MAX; i++) step(0, 1, 0, 0);
        chk("timeout_set", 32'(hazardTimeout), 32'd1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("timeout_sticky", 32'(hazardTimeout), 32'd1);
        step(1, 0, 0, 0);
        chk("timeout_cleared", 32'(hazardTimeout), 32'd0);

        // perf counters
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
`ifdef PIPE_STALL_PERF_EN
        chk("perf_stalls", stallCount, 32'd5);
        chk("perf_flushes", flushCount, 32'd2);
`else
        chk("perf_stalls", stallCount, 32'd0);
        chk("perf_flushes", flushCount, 32'd0);
`endif
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("perf_stalls_rst", stallCount, 32'd0);
        chk("perf_flushes_rst", flushCount, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 25));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
